// File: rtl/imem_loader.sv
// Loads a program into instruction memory from a byte stream: count byte, 2N
// instruction bytes (high byte first), then an XOR checksum byte.
module imem_loader #(
  parameter int ADDR_WIDTH = 8,
  parameter int INSTR_WIDTH = 16,
  parameter logic [ADDR_WIDTH-1:0] BASE_ADDR = '0
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   start,
  input  logic [7:0]             rx_data,
  input  logic                   rx_valid,
  output logic                   rx_ready,
  output logic                   imem_we,
  output logic [ADDR_WIDTH-1:0]  imem_addr,
  output logic [INSTR_WIDTH-1:0] imem_wdata,
  output logic                   cpu_hold,
  output logic                   busy,
  output logic                   done,
  output logic                   chk_err,
  output logic [8:0]             words_loaded
);

  typedef enum logic [2:0] {
    S_IDLE, S_COUNT, S_HI, S_LO, S_WRITE, S_CHECK, S_DONE
  } state_t;

  state_t state, next_state;

  logic [7:0]             count_q;
  logic [7:0]             idx_q;
  logic [7:0]             hi_q;
  logic [7:0]             xor_q;
  logic [ADDR_WIDTH-1:0]  addr_q;
  logic [INSTR_WIDTH-1:0] wdata_q;
  logic                   xfer;

  assign xfer = rx_valid && rx_ready;

  always_comb begin
    next_state = state;
    rx_ready   = 1'b0;
    case (state)
      S_IDLE: begin
        if (start) next_state = S_COUNT;
      end
      S_COUNT: begin
        rx_ready = 1'b1;
        if (xfer) next_state = (rx_data == 8'd0) ? S_CHECK : S_HI;
      end
      S_HI: begin
        rx_ready = 1'b1;
        if (xfer) next_state = S_LO;
      end
      S_LO: begin
        rx_ready = 1'b1;
        if (xfer) next_state = S_WRITE;
      end
      S_WRITE: begin
        next_state = (idx_q + 8'd1 == count_q) ? S_CHECK : S_HI;
      end
      S_CHECK: begin
        rx_ready = 1'b1;
        if (xfer) next_state = S_DONE;
      end
      S_DONE: begin
        next_state = S_IDLE;
      end
      default: next_state = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) state <= S_IDLE;
    else       state <= next_state;
  end

  // Write address/data are captured on the LO byte so they are stable during
  // WRITE and keep their last value afterwards.
  always_ff @(posedge clk) begin
    if (reset) begin
      count_q      <= '0;
      idx_q        <= '0;
      hi_q         <= '0;
      xor_q        <= '0;
      addr_q       <= '0;
      wdata_q      <= '0;
      chk_err      <= 1'b0;
      words_loaded <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (start) begin
            chk_err      <= 1'b0;
            words_loaded <= '0;
            xor_q        <= '0;
            idx_q        <= '0;
          end
        end
        S_COUNT: begin
          if (xfer) count_q <= rx_data;
        end
        S_HI: begin
          if (xfer) begin
            hi_q  <= rx_data;
            xor_q <= xor_q ^ rx_data;
          end
        end
        S_LO: begin
          if (xfer) begin
            wdata_q <= {hi_q, rx_data};
            addr_q  <= BASE_ADDR + ADDR_WIDTH'(idx_q);
            xor_q   <= xor_q ^ rx_data;
          end
        end
        S_WRITE: begin
          idx_q        <= idx_q + 8'd1;
          words_loaded <= words_loaded + 9'd1;
        end
        S_CHECK: begin
          if (xfer) chk_err <= (rx_data != xor_q);
        end
        default: ;
      endcase
    end
  end

  assign imem_we    = (state == S_WRITE);
  assign imem_addr  = addr_q;
  assign imem_wdata = wdata_q;
  assign cpu_hold   = (state != S_IDLE);
  assign busy       = (state != S_IDLE);
  assign done       = (state == S_DONE);

endmodule
